pktbuf_arbiter: RTL and testbench
=================================

PKTBUF_ARBITER -- requirements
Module: pktbuf_arbiter

Interface
REQ-001 The block SHALL have parameter CNT_WIDTH, default 32, which is the width of the statistics counters (REQ-029).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port sn_done, input, 1 bit: one-cycle pulse; the snooper has finished writing its current buffer.
REQ-005 The block SHALL have ports cpu_acc and cpu_rej, input, 1 bit each: one-cycle pulses; the CPU accepts or rejects the packet in its current buffer.
REQ-006 The block SHALL have port fwd_done, input, 1 bit: one-cycle pulse; the forwarder has finished reading its current buffer.
REQ-007 The block SHALL have ports sn_sel, cpu_sel and fwd_sel, output, 2 bits each: buffer granted to the agent; 00 none, 01 ping, 10 pang, 11 pung; these drive the packet-memory mux selects directly.
REQ-008 The block SHALL have ports sn_rdy, cpu_rdy and fwd_rdy, output, 1 bit each: the matching select is non-zero.

Function
REQ-009 Each buffer SHALL hold one state: EMPTY, SN (being written), WAIT_CPU, CPU (being filtered), WAIT_FWD, FWD (being read), or REJ.
REQ-010 Each agent SHALL have a 2-bit ring pointer (ping, pang, pung, ping, ...), and buffers SHALL be granted strictly in ring order so packet order is preserved.
REQ-011 When sn_sel is 00 and the buffer at the snooper pointer is EMPTY, that buffer SHALL become SN and sn_sel SHALL show it on the next cycle.
REQ-012 When cpu_sel is 00 and the buffer at the CPU pointer is WAIT_CPU, that buffer SHALL become CPU.
REQ-013 When fwd_sel is 00 and the buffer at the forwarder pointer is WAIT_FWD, that buffer SHALL become FWD.
REQ-014 sn_done while sn_rdy SHALL move the buffer SN to WAIT_CPU, advance the snooper pointer, and set sn_sel to 00 on the next cycle.
REQ-015 cpu_acc while cpu_rdy SHALL move the buffer CPU to WAIT_FWD; cpu_rej SHALL move it to REJ; either SHALL advance the CPU pointer and set cpu_sel to 00 on the next cycle.
REQ-016 fwd_done while fwd_rdy SHALL move the buffer FWD to EMPTY, advance the forwarder pointer, and set fwd_sel to 00 on the next cycle.
REQ-017 A REJ buffer at the forwarder pointer while fwd_sel is 00 SHALL become EMPTY in one cycle and advance the forwarder pointer, with fwd_sel held at 00 throughout.
REQ-018 A done/acc/rej pulse while the agent's rdy is 0 SHALL be ignored.
REQ-019 cpu_acc and cpu_rej asserted in the same cycle SHALL be treated as cpu_rej.
REQ-020 Release-to-next-grant latency SHALL be 2 cycles: done at edge N, sel at 00 for cycle N+1, next grant visible from edge N+2.
REQ-021 Idle-to-grant latency SHALL be 1 cycle after the qualifying state appears.
REQ-022 All three agents SHALL be able to release and/or be granted in the same cycle; each buffer has a single owner, so no conflict is possible.
REQ-023 When no buffer qualifies, the agent's sel SHALL stay 00 indefinitely (snooper backpressure / drop is the snooper's concern).
REQ-024 All outputs SHALL be decoded from registers only, with no combinational input-to-output path.
REQ-025 No two sel outputs SHALL ever be equal and non-zero.

Reset
REQ-026 While rst_n is 0, all buffers SHALL be EMPTY, all pointers SHALL be ping, all sel outputs SHALL be 00 and all rdy outputs SHALL be 0.
REQ-027 Reset asserted mid-operation SHALL abandon all packets without completing any handshake.
REQ-028 On the first edge after rst_n deasserts, the snooper SHALL be granted ping (sn_sel=01 from cycle 1).

Configuration
REQ-029 With PKTBUF_ARB_STATS_EN defined, the block SHALL add outputs acc_cnt, rej_cnt and fwd_cnt, each CNT_WIDTH bits; these count cpu_acc, cpu_rej and fwd_done events honoured under REQ-015, REQ-016 and REQ-018, saturate at all-ones, and reset to 0.
REQ-030 With PKTBUF_ARB_STATS_EN undefined, those ports and counters SHALL not exist, and behaviour SHALL otherwise be identical.

Structure
REQ-031 A shared package SHALL hold the select encodings (SEL_NONE, SEL_PING, SEL_PANG, SEL_PUNG), the buffer-state enumeration, and the ring-increment function.
REQ-032 The per-buffer state machine SHALL be sub-module pktbuf_state, instantiated three times; pointers, grant logic and statistics SHALL reside in pktbuf_arbiter.

Verification
REQ-033 Release reset, then pulse sn_done at cycle 3 -> sn_sel 01 in cycles 1-3, 00 in cycle 4, 10 from cycle 5; cpu_sel 01 from cycle 5.
REQ-034 Fill ping, accept it, fill pang, reject it -> fwd_sel 01; after fwd_done, pang is freed via REJ with fwd_sel never 10; fwd_pointer then at pung.
REQ-035 Snooper fills all three buffers while CPU is idle -> sn_sel 00 and held until the CPU accepts ping and the forwarder completes ping; then sn_sel becomes 01.
REQ-036 Same-cycle sn_done, cpu_acc and fwd_done on three different buffers -> all three transitions apply; REQ-025 holds every cycle (assertion).
REQ-037 Pulse rst_n low while cpu_sel is 10 and fwd_sel is 01 -> all sel 00 asynchronously; after release, sn_sel 01 and the stats counters are 0.
REQ-038 With PKTBUF_ARB_STATS_EN and CNT_WIDTH=2, send 5 accepted packets -> acc_cnt saturates at 3; rej_cnt 0; fwd_cnt 3.

Source files
------------

// File: rtl/pktbuf_arbiter_pkg.sv
// Shared definitions for the ping/pang/pung packet-buffer arbiter:
// select encodings, per-buffer state enumeration and ring stepping.
package pktbuf_arbiter_pkg;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_PING = 2'b01;
    localparam logic [1:0] SEL_PANG = 2'b10;
    localparam logic [1:0] SEL_PUNG = 2'b11;

    localparam int unsigned NUM_BUFS = 3;

    typedef enum logic [2:0] {
        BUF_EMPTY    = 3'd0,
        BUF_SN       = 3'd1,
        BUF_WAIT_CPU = 3'd2,
        BUF_CPU      = 3'd3,
        BUF_WAIT_FWD = 3'd4,
        BUF_FWD      = 3'd5,
        BUF_REJ      = 3'd6
    } buf_state_e;

    // Pointers only ever hold ping/pang/pung; anything else restarts at ping.
    function automatic logic [1:0] ring_inc(input logic [1:0] sel);
        case (sel)
            SEL_PING: return SEL_PANG;
            SEL_PANG: return SEL_PUNG;
            default:  return SEL_PING;
        endcase
    endfunction

endpackage

// File: rtl/pktbuf_state.sv
// Lifecycle of one packet buffer: snooper fill, CPU filter, forwarder drain
// or reject-free. All qualifying events come from pktbuf_arbiter.
module pktbuf_state
    import pktbuf_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sn_grant,
    input  logic       sn_rel,
    input  logic       cpu_grant,
    input  logic       cpu_acc,
    input  logic       cpu_rej,
    input  logic       fwd_grant,
    input  logic       fwd_rel,
    input  logic       rej_free,
    output buf_state_e state
);

    buf_state_e state_q;
    buf_state_e state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BUF_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BUF_EMPTY:    if (sn_grant)  state_d = BUF_SN;
            BUF_SN:       if (sn_rel)    state_d = BUF_WAIT_CPU;
            BUF_WAIT_CPU: if (cpu_grant) state_d = BUF_CPU;
            BUF_CPU: begin
                // Reject dominates a simultaneous accept.
                if (cpu_rej)      state_d = BUF_REJ;
                else if (cpu_acc) state_d = BUF_WAIT_FWD;
            end
            BUF_WAIT_FWD: if (fwd_grant) state_d = BUF_FWD;
            BUF_FWD:      if (fwd_rel)   state_d = BUF_EMPTY;
            BUF_REJ:      if (rej_free)  state_d = BUF_EMPTY;
            default:                     state_d = BUF_EMPTY;
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/pktbuf_arbiter.sv
// Three-buffer ring arbiter between snooper, CPU filter and forwarder.
// Optional statistics counters are built when PKTBUF_ARB_STATS_EN is defined.
module pktbuf_arbiter
    import pktbuf_arbiter_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sn_done,
    input  logic                 cpu_acc,
    input  logic                 cpu_rej,
    input  logic                 fwd_done,
    output logic [1:0]           sn_sel,
    output logic [1:0]           cpu_sel,
    output logic [1:0]           fwd_sel,
    output logic                 sn_rdy,
    output logic                 cpu_rdy,
    output logic                 fwd_rdy
`ifdef PKTBUF_ARB_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] acc_cnt,
    output logic [CNT_WIDTH-1:0] rej_cnt,
    output logic [CNT_WIDTH-1:0] fwd_cnt
`endif
);

    if (CNT_WIDTH < 1) begin : g_cnt_width_check
        $error("pktbuf_arbiter: CNT_WIDTH must be at least 1");
    end

    logic [1:0] sn_sel_q, cpu_sel_q, fwd_sel_q;
    logic [1:0] sn_ptr_q, cpu_ptr_q, fwd_ptr_q;

    buf_state_e buf_st [NUM_BUFS];

    logic [NUM_BUFS-1:0] sn_grant, sn_rel_v;
    logic [NUM_BUFS-1:0] cpu_grant, cpu_acc_v, cpu_rej_v;
    logic [NUM_BUFS-1:0] fwd_grant, fwd_rel_v, rej_free;

    logic sn_busy, cpu_busy, fwd_busy;
    logic sn_rel, cpu_rel, cpu_acc_ok, cpu_rej_ok, fwd_rel;

    assign sn_busy  = (sn_sel_q  != SEL_NONE);
    assign cpu_busy = (cpu_sel_q != SEL_NONE);
    assign fwd_busy = (fwd_sel_q != SEL_NONE);

    // Pulses only count while the agent actually owns a buffer.
    assign sn_rel     = sn_done  && sn_busy;
    assign cpu_rej_ok = cpu_rej  && cpu_busy;
    assign cpu_acc_ok = cpu_acc  && !cpu_rej && cpu_busy;
    assign cpu_rel    = cpu_acc_ok || cpu_rej_ok;
    assign fwd_rel    = fwd_done && fwd_busy;

    for (genvar g = 0; g < NUM_BUFS; g++) begin : g_buf
        localparam logic [1:0] BUF_SEL = 2'(g + 1);

        assign sn_grant[g]  = !sn_busy  && (sn_ptr_q  == BUF_SEL) && (buf_st[g] == BUF_EMPTY);
        assign cpu_grant[g] = !cpu_busy && (cpu_ptr_q == BUF_SEL) && (buf_st[g] == BUF_WAIT_CPU);
        assign fwd_grant[g] = !fwd_busy && (fwd_ptr_q == BUF_SEL) && (buf_st[g] == BUF_WAIT_FWD);
        assign rej_free[g]  = !fwd_busy && (fwd_ptr_q == BUF_SEL) && (buf_st[g] == BUF_REJ);

        assign sn_rel_v[g]  = sn_rel     && (sn_sel_q  == BUF_SEL);
        assign cpu_acc_v[g] = cpu_acc_ok && (cpu_sel_q == BUF_SEL);
        assign cpu_rej_v[g] = cpu_rej_ok && (cpu_sel_q == BUF_SEL);
        assign fwd_rel_v[g] = fwd_rel    && (fwd_sel_q == BUF_SEL);

        pktbuf_state u_state (
            .clk       (clk),
            .rst_n     (rst_n),
            .sn_grant  (sn_grant[g]),
            .sn_rel    (sn_rel_v[g]),
            .cpu_grant (cpu_grant[g]),
            .cpu_acc   (cpu_acc_v[g]),
            .cpu_rej   (cpu_rej_v[g]),
            .fwd_grant (fwd_grant[g]),
            .fwd_rel   (fwd_rel_v[g]),
            .rej_free  (rej_free[g]),
            .state     (buf_st[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sn_sel_q  <= SEL_NONE;
            cpu_sel_q <= SEL_NONE;
            fwd_sel_q <= SEL_NONE;
            sn_ptr_q  <= SEL_PING;
            cpu_ptr_q <= SEL_PING;
            fwd_ptr_q <= SEL_PING;
        end else begin
            if (sn_rel) begin
                sn_sel_q <= SEL_NONE;
                sn_ptr_q <= ring_inc(sn_ptr_q);
            end else if (|sn_grant) begin
                sn_sel_q <= sn_ptr_q;
            end

            if (cpu_rel) begin
                cpu_sel_q <= SEL_NONE;
                cpu_ptr_q <= ring_inc(cpu_ptr_q);
            end else if (|cpu_grant) begin
                cpu_sel_q <= cpu_ptr_q;
            end

            // A rejected buffer is skipped by the forwarder without a grant.
            if (fwd_rel) begin
                fwd_sel_q <= SEL_NONE;
                fwd_ptr_q <= ring_inc(fwd_ptr_q);
            end else if (|fwd_grant) begin
                fwd_sel_q <= fwd_ptr_q;
            end else if (|rej_free) begin
                fwd_ptr_q <= ring_inc(fwd_ptr_q);
            end
        end
    end

    assign sn_sel  = sn_sel_q;
    assign cpu_sel = cpu_sel_q;
    assign fwd_sel = fwd_sel_q;
    assign sn_rdy  = sn_busy;
    assign cpu_rdy = cpu_busy;
    assign fwd_rdy = fwd_busy;

`ifdef PKTBUF_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] acc_cnt_q, rej_cnt_q, fwd_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt_q <= '0;
            rej_cnt_q <= '0;
            fwd_cnt_q <= '0;
        end else begin
            if (cpu_acc_ok && (acc_cnt_q != '1)) acc_cnt_q <= acc_cnt_q + 1'b1;
            if (cpu_rej_ok && (rej_cnt_q != '1)) rej_cnt_q <= rej_cnt_q + 1'b1;
            if (fwd_rel    && (fwd_cnt_q != '1)) fwd_cnt_q <= fwd_cnt_q + 1'b1;
        end
    end

    assign acc_cnt = acc_cnt_q;
    assign rej_cnt = rej_cnt_q;
    assign fwd_cnt = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_pktbuf_arbiter.sv
// Directed bench for pktbuf_arbiter; statistics checks are included when
// PKTBUF_ARB_STATS_EN is defined (instance uses CNT_WIDTH=2).
module tb_pktbuf_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sn_done = 1'b0;
    logic       cpu_acc = 1'b0;
    logic       cpu_rej = 1'b0;
    logic       fwd_done = 1'b0;
    logic [1:0] sn_sel, cpu_sel, fwd_sel;
    logic       sn_rdy, cpu_rdy, fwd_rdy;
`ifdef PKTBUF_ARB_STATS_EN
    logic [1:0] acc_cnt, rej_cnt, fwd_cnt;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic        watch_no_pang = 1'b0;

    always #5 clk = ~clk;

    pktbuf_arbiter #(.CNT_WIDTH(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sn_done  (sn_done),
        .cpu_acc  (cpu_acc),
        .cpu_rej  (cpu_rej),
        .fwd_done (fwd_done),
        .sn_sel   (sn_sel),
        .cpu_sel  (cpu_sel),
        .fwd_sel  (fwd_sel),
        .sn_rdy   (sn_rdy),
        .cpu_rdy  (cpu_rdy),
        .fwd_rdy  (fwd_rdy)
`ifdef PKTBUF_ARB_STATS_EN
        ,
        .acc_cnt  (acc_cnt),
        .rej_cnt  (rej_cnt),
        .fwd_cnt  (fwd_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_sels(input string tag, input logic [1:0] s, input logic [1:0] c,
                              input logic [1:0] f);
        check({tag, "_sn"},  32'(sn_sel),  32'(s));
        check({tag, "_cpu"}, 32'(cpu_sel), 32'(c));
        check({tag, "_fwd"}, 32'(fwd_sel), 32'(f));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sn();
        sn_done = 1'b1; tick(); sn_done = 1'b0;
    endtask

    task automatic pulse_acc();
        cpu_acc = 1'b1; tick(); cpu_acc = 1'b0;
    endtask

    task automatic pulse_fwd();
        fwd_done = 1'b1; tick(); fwd_done = 1'b0;
    endtask

    // which: 0 snooper, 1 cpu, 2 forwarder
    task automatic wait_rdy(input int which, input string tag);
        logic r;
        for (int i = 0; i < 20; i++) begin
            r = (which == 0) ? sn_rdy : (which == 1) ? cpu_rdy : fwd_rdy;
            if (r) break;
            tick();
        end
        r = (which == 0) ? sn_rdy : (which == 1) ? cpu_rdy : fwd_rdy;
        check(tag, 32'(r), 32'd1);
    endtask

    // Grant exclusivity and the no-forward-of-rejected-pang watch, every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            check("sel_unique",
                  32'((sn_sel != 2'b00 && (sn_sel == cpu_sel || sn_sel == fwd_sel)) ||
                      (cpu_sel != 2'b00 && cpu_sel == fwd_sel)), 32'd0);
            if (watch_no_pang) check("fwd_not_pang", 32'(fwd_sel == 2'b10), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        tick(); tick();
        check_sels("rst", 2'b00, 2'b00, 2'b00);
        check("rst_rdy", 32'({sn_rdy, cpu_rdy, fwd_rdy}), 32'd0);
        rst_n = 1'b1;

        // Release, first grant, sn_done at cycle 3
        tick();                                   // cycle 1
        check("c1_sn", 32'(sn_sel), 32'h1);
        check("c1_snrdy", 32'(sn_rdy), 32'd1);
        tick();  check("c2_sn", 32'(sn_sel), 32'h1);
        tick();  check("c3_sn", 32'(sn_sel), 32'h1);
        pulse_sn();                               // cycle 4
        check_sels("c4", 2'b00, 2'b00, 2'b00);
        tick();                                   // cycle 5
        check_sels("c5", 2'b10, 2'b01, 2'b00);

        // Accept ping; stray fwd_done while forwarder idle is ignored
        cpu_acc = 1'b1; fwd_done = 1'b1; tick(); cpu_acc = 1'b0; fwd_done = 1'b0;  // cycle 6
        check_sels("c6", 2'b10, 2'b00, 2'b00);
        pulse_sn();                               // cycle 7
        check_sels("c7", 2'b00, 2'b00, 2'b01);
        tick();                                   // cycle 8
        check_sels("c8", 2'b11, 2'b10, 2'b01);

        // acc+rej together rejects pang
        cpu_acc = 1'b1; cpu_rej = 1'b1; tick(); cpu_acc = 1'b0; cpu_rej = 1'b0;    // cycle 9
        check_sels("c9", 2'b11, 2'b00, 2'b01);
        watch_no_pang = 1'b1;
        // fwd_done on ping plus a cpu_acc while cpu idle (ignored)
        cpu_acc = 1'b1; fwd_done = 1'b1; tick(); cpu_acc = 1'b0; fwd_done = 1'b0;  // cycle 10
        check_sels("c10", 2'b11, 2'b00, 2'b00);
        tick();  check("c11_fwd", 32'(fwd_sel), 32'h0);
        tick();  check("c12_fwd", 32'(fwd_sel), 32'h0);
        pulse_sn();                               // cycle 13
        check_sels("c13", 2'b00, 2'b00, 2'b00);
        tick();                                   // cycle 14
        check_sels("c14", 2'b01, 2'b11, 2'b00);
        pulse_acc();                              // cycle 15
        check_sels("c15", 2'b01, 2'b00, 2'b00);
        tick();                                   // cycle 16: forwarder pointer reached pung
        check_sels("c16", 2'b01, 2'b00, 2'b11);
        watch_no_pang = 1'b0;
        pulse_fwd();                              // cycle 17
        check("c17_fwd", 32'(fwd_sel), 32'h0);
`ifdef PKTBUF_ARB_STATS_EN
        check("c17_acc", 32'(acc_cnt), 32'd2);
        check("c17_rej", 32'(rej_cnt), 32'd1);
        check("c17_fcnt", 32'(fwd_cnt), 32'd2);
`endif

        // Snooper fills all three while CPU holds ping
        pulse_sn();                               // cycle 18
        tick();                                   // cycle 19
        check_sels("c19", 2'b10, 2'b01, 2'b00);
        pulse_sn();                               // cycle 20
        tick();  check("c21_sn", 32'(sn_sel), 32'h3);
        pulse_sn();                               // cycle 22
        check("c22_sn", 32'(sn_sel), 32'h0);
        for (int i = 23; i <= 27; i++) begin
            tick();
            check("full_sn_hold", 32'(sn_sel), 32'h0);
        end
        check("c27_cpu", 32'(cpu_sel), 32'h1);
        pulse_acc();                              // cycle 28
        check_sels("c28", 2'b00, 2'b00, 2'b00);
        tick();                                   // cycle 29
        check_sels("c29", 2'b00, 2'b10, 2'b01);
        pulse_fwd();                              // cycle 30
        check_sels("c30", 2'b00, 2'b10, 2'b00);
        tick();                                   // cycle 31
        check("c31_sn", 32'(sn_sel), 32'h1);

        // Simultaneous release by all three agents
        pulse_acc();                              // cycle 32
        tick();                                   // cycle 33
        check_sels("c33", 2'b01, 2'b11, 2'b10);
        sn_done = 1'b1; cpu_acc = 1'b1; fwd_done = 1'b1;
        tick();                                   // cycle 34
        sn_done = 1'b0; cpu_acc = 1'b0; fwd_done = 1'b0;
        check_sels("c34", 2'b00, 2'b00, 2'b00);
        tick();                                   // cycle 35
        check_sels("c35", 2'b10, 2'b01, 2'b11);
`ifdef PKTBUF_ARB_STATS_EN
        check("c35_acc", 32'(acc_cnt), 32'd3);
        check("c35_fcnt", 32'(fwd_cnt), 32'd3);
`endif

        // Fresh start, build cpu_sel=10 / fwd_sel=01, then reset mid-flight
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        tick();                                   // cycle 1
        pulse_sn();                               // cycle 2
        tick();                                   // cycle 3
        pulse_acc();                              // cycle 4
        pulse_sn();                               // cycle 5
        tick();                                   // cycle 6
        check_sels("r6", 2'b11, 2'b10, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        check_sels("async_rst", 2'b00, 2'b00, 2'b00);
        check("async_rst_rdy", 32'({sn_rdy, cpu_rdy, fwd_rdy}), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check_sels("rel1", 2'b01, 2'b00, 2'b00);
`ifdef PKTBUF_ARB_STATS_EN
        check("rel_acc", 32'(acc_cnt), 32'd0);
        check("rel_rej", 32'(rej_cnt), 32'd0);
        check("rel_fcnt", 32'(fwd_cnt), 32'd0);
`endif

        // Five accepted packets, one at a time
        for (int p = 0; p < 5; p++) begin
            wait_rdy(0, "wait_sn");
            pulse_sn();
            wait_rdy(1, "wait_cpu");
            pulse_acc();
            wait_rdy(2, "wait_fwd");
            pulse_fwd();
        end
        tick();
        check_sels("pkt5", 2'b11, 2'b00, 2'b00);
`ifdef PKTBUF_ARB_STATS_EN
        check("sat_acc", 32'(acc_cnt), 32'd3);
        check("sat_rej", 32'(rej_cnt), 32'd0);
        check("sat_fcnt", 32'(fwd_cnt), 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
